gpr_hilo_file: RTL

//   Architectural state sink at the far end of the write-back bus: holds the 32x32 MIPS

---
 rtl/gpr_hilo_file.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gpr_hilo_file.sv
// gpr_hilo_file: architectural register state at the end of the write-back bus.
// Holds the 31 writable MIPS GPRs (r0 is hard-wired to zero and not stored)
// plus HI and LO. Writes commit on posedge clk. Reads are combinational and
// write-first: a write presented on the bus this cycle is visible on the read
// ports before it commits. Reset is asynchronous and active-high.
module gpr_hilo_file #(
    parameter int          WB_TO_RF_WD = 104,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [4:0]             raddr1,
    output logic [31:0]            rdata1,
    input  logic [4:0]             raddr2,
    output logic [31:0]            rdata2,
    output logic [31:0]            hi_rdata,
    output logic [31:0]            lo_rdata
);

    // Write-back bus fields
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_result;
    logic [31:0] lo_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign hi_we     = wb_to_rf_bus[103];
    assign lo_we     = wb_to_rf_bus[102];
    assign hi_result = wb_to_rf_bus[101:70];
    assign lo_result = wb_to_rf_bus[69:38];
    assign rf_we     = wb_to_rf_bus[37];
    assign rf_waddr  = wb_to_rf_bus[36:32];
    assign rf_wdata  = wb_to_rf_bus[31:0];

    // Architectural state; index 0 does not exist, r0 is synthesised as zero.
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic [31:0] hi_q;
    logic [31:0] hi_d;
    logic [31:0] lo_q;
    logic [31:0] lo_d;

    // Next-state decode. Each register compares its own index against the
    // write address, so an unknown enable falls to the hold branch and never
    // disturbs registers it does not address.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if ((rf_we == 1'b1) && (rf_waddr == 5'(i))) begin
                regs_d[i] = rf_wdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        hi_d = hi_q;
        if (hi_we == 1'b1) begin
            hi_d = hi_result;
        end else begin
            hi_d = hi_q;
        end
        lo_d = lo_q;
        if (lo_we == 1'b1) begin
            lo_d = lo_result;
        end else begin
            lo_d = lo_q;
        end
    end

    // State registers; an edge while rst is high commits nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            hi_q <= RESET_VAL;
            lo_q <= RESET_VAL;
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // GPR read port 1: r0 reads zero, then write-first bypass, then storage.
    always_comb begin
        rdata1 = 32'h0000_0000;
        if (raddr1 == 5'd0) begin
            rdata1 = 32'h0000_0000;
        end else if (!rst && (rf_we == 1'b1) && (rf_waddr == raddr1)) begin
            rdata1 = rf_wdata;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (raddr1 == 5'(i)) begin
                    rdata1 = regs_q[i];
                end else begin
                    rdata1 = rdata1;
                end
            end
        end
    end

    // GPR read port 2: same priority as port 1, decoded independently.
    always_comb begin
        rdata2 = 32'h0000_0000;
        if (raddr2 == 5'd0) begin
            rdata2 = 32'h0000_0000;
        end else if (!rst && (rf_we == 1'b1) && (rf_waddr == raddr2)) begin
            rdata2 = rf_wdata;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (raddr2 == 5'(i)) begin
                    rdata2 = regs_q[i];
                end else begin
                    rdata2 = rdata2;
                end
            end
        end
    end

    // HI/LO read ports with bypass, suppressed while reset holds the state.
    always_comb begin
        hi_rdata = hi_q;
        lo_rdata = lo_q;
        if (!rst && (hi_we == 1'b1)) begin
            hi_rdata = hi_result;
        end else begin
            hi_rdata = hi_q;
        end
        if (!rst && (lo_we == 1'b1)) begin
            lo_rdata = lo_result;
        end else begin
            lo_rdata = lo_q;
        end
    end

endmodule
